fifo_uart_tx: RTL and testbench

//   Downstream consumer of the fifo block: pops words from the fifo read side and transmits each word as one UART frame.

---
 rtl/fifo_uart_tx.sv | 144 ++++++++++++++
 tb/tb_fifo_uart_tx.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops words from a registered-output fifo and sends each one
// as a UART frame: start bit, WIDTH data bits LSB first, optional parity bit,
// then STOP_BITS stop bits. The serial line idles high.
module fifo_uart_tx #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = 0,   // 0 none, 1 even, 2 odd
  parameter int STOP_BITS    = 1    // 1 or 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             enable,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             fifo_rd_en,
  output logic             tx,
  output logic             busy
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  state_t             state;
  logic [BAUD_W-1:0]  baud_cnt;
  logic [BIT_W-1:0]   bit_cnt;
  logic [WIDTH-1:0]   shreg;
  logic               par_bit;
  logic               bit_end;
  logic [WIDTH-1:0]   shreg_nxt;

  // Last cycle of the current serial bit period.
  assign bit_end   = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));
  assign shreg_nxt = shreg >> 1;

  // Pop only from IDLE; gated by rstn so no pop can leak out while in reset.
  assign fifo_rd_en = (state == S_IDLE) & enable & ~fifo_empty & rstn;

  assign busy = (state != S_IDLE);

  // Frame sequencer: owns state, counters, shift register and the tx line.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      tx       <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          tx       <= 1'b1;
          baud_cnt <= '0;
          bit_cnt  <= '0;
          if (fifo_rd_en) state <= S_FETCH;
        end

        // Registered fifo data is valid now; the start bit goes out next.
        S_FETCH: begin
          shreg    <= fifo_data;
          par_bit  <= (PARITY == 2) ? ~^fifo_data : ^fifo_data;
          baud_cnt <= '0;
          bit_cnt  <= '0;
          tx       <= 1'b0;
          state    <= S_START;
        end

        S_START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            tx       <= shreg[0];
            state    <= S_DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        S_DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            shreg    <= shreg_nxt;
            if (bit_cnt == BIT_W'(WIDTH - 1)) begin
              bit_cnt <= '0;
              if (PARITY != 0) begin
                tx    <= par_bit;
                state <= S_PAR;
              end else begin
                tx    <= 1'b1;
                state <= S_STOP;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              tx      <= shreg_nxt[0];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        S_PAR: begin
          if (bit_end) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            tx       <= 1'b1;
            state    <= S_STOP;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        // bit_cnt is reused here to count stop bit periods.
        S_STOP: begin
          tx <= 1'b1;
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_cnt == BIT_W'(STOP_BITS - 1)) begin
              bit_cnt <= '0;
              state   <= S_IDLE;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        default: begin
          tx    <= 1'b1;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: three instances (no parity / even parity / odd
// parity with two stop bits) each fed by a small fifo model. Every pushed word
// is queued as an expected frame; a per-instance line monitor rebuilds the
// exact waveform of that frame cycle by cycle and compares it to tx.
module tb_fifo_uart_tx;
  localparam int CPB = 4;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic enable = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]      empty, rd_en, tx, busy;
  logic [2:0][7:0] fdata;

  logic [7:0] mem [3][64];
  int wp[3] = '{0, 0, 0};
  int rp[3] = '{0, 0, 0};
  int cyc = 0;
  int rd_cnt[3]   = '{0, 0, 0};
  int rd_cyc[3]   = '{0, 0, 0};
  int last_end[3] = '{0, 0, 0};
  int gap[3]      = '{0, 0, 0};
  int frames[3]   = '{0, 0, 0};
  logic rec_par[3];
  logic [7:0] exp0[$], exp1[$], exp2[$];
  int n_tests = 0;
  int n_fail  = 0;

  fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(1)) u_dut0 (
    .clk(clk), .rstn(rstn), .enable(enable), .fifo_empty(empty[0]),
    .fifo_data(fdata[0]), .fifo_rd_en(rd_en[0]), .tx(tx[0]), .busy(busy[0]));
  fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY(1), .STOP_BITS(1)) u_dut1 (
    .clk(clk), .rstn(rstn), .enable(enable), .fifo_empty(empty[1]),
    .fifo_data(fdata[1]), .fifo_rd_en(rd_en[1]), .tx(tx[1]), .busy(busy[1]));
  fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY(2), .STOP_BITS(2)) u_dut2 (
    .clk(clk), .rstn(rstn), .enable(enable), .fifo_empty(empty[2]),
    .fifo_data(fdata[2]), .fifo_rd_en(rd_en[2]), .tx(tx[2]), .busy(busy[2]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_tests++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, expv, $time);
    end
  endtask

  // fifo model: registered read data, one word per rd_en
  always_comb for (int i = 0; i < 3; i++) empty[i] = (wp[i] == rp[i]);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 3; i++)
      if (rd_en[i]) begin
        fdata[i] <= mem[i][rp[i] % 64];
        rp[i]    <= rp[i] + 1;
      end
  end

  always @(negedge clk)
    for (int i = 0; i < 3; i++)
      if (rd_en[i]) begin
        rd_cnt[i]++;
        rd_cyc[i] = cyc;
      end

  task automatic push(input int i, input logic [7:0] w);
    mem[i][wp[i] % 64] = w;
    wp[i]++;
    case (i)
      0: exp0.push_back(w);
      1: exp1.push_back(w);
      default: exp2.push_back(w);
    endcase
  endtask

  function automatic int exp_size(input int i);
    case (i)
      0: return exp0.size();
      1: return exp1.size();
      default: return exp2.size();
    endcase
  endfunction

  function automatic logic [7:0] pop_exp(input int i);
    logic [7:0] w;
    w = 8'h00;
    case (i)
      0: if (exp0.size() > 0) w = exp0.pop_front();
      1: if (exp1.size() > 0) w = exp1.pop_front();
      default: if (exp2.size() > 0) w = exp2.pop_front();
    endcase
    return w;
  endfunction

  // Line monitor: on a start bit, pop the expected word and check every
  // cycle of the frame against the waveform rebuilt from that word.
  task automatic watch(input int i, input int par, input int stops);
    int total, bad, p;
    logic [7:0] w;
    logic b;
    bit abort;
    total = (1 + 8 + ((par != 0) ? 1 : 0) + stops) * CPB;
    forever begin
      @(negedge clk);
      if (rstn && tx[i] === 1'b0) begin
        chk($sformatf("rd2start%0d", i), cyc - rd_cyc[i], 2);
        if (last_end[i] > 0) gap[i] = cyc - last_end[i] - 1;
        if (exp_size(i) == 0) chk($sformatf("exp_avail%0d", i), 0, 1);
        w = pop_exp(i);
        bad = 0;
        abort = 0;
        for (int k = 0; k < total; k++) begin
          if (k > 0) @(negedge clk);
          if (!rstn) begin
            abort = 1;
            break;
          end
          p = k / CPB;
          if (p == 0) b = 1'b0;
          else if (p <= 8) b = w[p-1];
          else if (p == 9 && par != 0) b = (par == 1) ? ^w : ~^w;
          else b = 1'b1;
          if (p == 9 && par != 0) rec_par[i] = tx[i];
          if (tx[i] !== b || busy[i] !== 1'b1) bad++;
        end
        if (!abort) begin
          chk($sformatf("frame%0d_%02h", i, w), bad, 0);
          frames[i]++;
          last_end[i] = cyc;
        end
      end
    end
  endtask

  initial watch(0, 0, 1);
  initial watch(1, 1, 1);
  initial watch(2, 2, 2);

  task automatic wait_idle(input int maxc);
    bit done;
    done = 0;
    for (int k = 0; k < maxc && !done; k++) begin
      @(negedge clk);
      if (busy == 3'b000 && empty == 3'b111) done = 1;
    end
    if (!done) chk("idle_timeout", 0, 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_rd0(input int maxc);
    bit done;
    done = 0;
    for (int k = 0; k < maxc && !done; k++) begin
      @(negedge clk);
      if (rd_en[0]) done = 1;
    end
    if (!done) chk("rd_timeout", 0, 1);
  endtask

  initial begin
    // reset with data waiting and enable high: no pop may escape
    enable = 1'b1;
    push(0, 8'hA5);
    push(1, 8'h07);
    push(2, 8'h07);
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 3'b111);
    chk("rst_busy", busy, 3'b000);
    chk("rst_rden", rd_en, 3'b000);
    @(posedge clk); #1 rstn = 1'b1;

    // single frames: 0xA5 plain, 0x07 even and odd parity
    wait_idle(400);
    chk("t2_rd_cnt", rd_cnt[0], 1);
    chk("t2_frames", frames[0], 1);
    chk("t2_busy", busy, 3'b000);
    chk("t2_tx_idle", tx, 3'b111);
    chk("t4_frames1", frames[1], 1);
    chk("t4_frames2", frames[2], 1);
    chk("t4_par_even", rec_par[1], 1);
    chk("t4_par_odd", rec_par[2], 0);

    // back-to-back frames
    @(posedge clk); #1;
    push(0, 8'h00); push(0, 8'hFF);
    push(2, 8'h55); push(2, 8'hAA);
    wait_idle(400);
    chk("t3_rd_cnt", rd_cnt[0], 3);
    chk("t3_frames", frames[0], 3);
    chk("t3_gap", gap[0], 2);
    chk("t3_empty", empty[0], 1);
    chk("t3_gap_2stop", gap[2], 2);
    chk("t3_frames2", frames[2], 3);

    // enable dropped during bit 3 of 0x3C
    @(posedge clk); #1;
    push(0, 8'h3C); push(0, 8'h11); push(0, 8'h22);
    wait_rd0(60);
    repeat (19) @(negedge clk);
    enable = 1'b0;
    repeat (120) @(negedge clk);
    chk("t5_rd_hold", rd_cnt[0], 4);
    chk("t5_frames", frames[0], 4);
    chk("t5_busy", busy[0], 0);
    chk("t5_not_empty", empty[0], 0);
    @(posedge clk); #1 enable = 1'b1;
    wait_idle(400);
    chk("t5_rd_resume", rd_cnt[0], 6);
    chk("t5_frames_resume", frames[0], 6);

    // reset during bit 5 of 0x81; 0x42 must follow intact
    @(posedge clk); #1;
    push(0, 8'h81); push(0, 8'h42);
    wait_rd0(60);
    repeat (27) @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("t6_tx_async", tx[0], 1);
    chk("t6_busy_async", busy[0], 0);
    chk("t6_rden_async", rd_en[0], 0);
    repeat (2) @(negedge clk);
    chk("t6_tx_hold", tx, 3'b111);
    chk("t6_busy_hold", busy, 3'b000);
    chk("t6_rden_hold", rd_en, 3'b000);
    @(posedge clk); #1 rstn = 1'b1;
    wait_idle(400);
    chk("t6_rd_cnt", rd_cnt[0], 8);
    chk("t6_frames", frames[0], 7);
    chk("t6_exp_drained", exp0.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
